// File: rtl/decoder_pkg.sv
// Shared constants for the decoder_scan slice: FSM state encoding and request modes.
package decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_SCAN = 2'd2
   } state_e;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage : decoder_pkg

// File: rtl/decoder_scan_onehot_dec.sv
// Combinational N-to-2^N one-hot decoder with enable, built recursively from 2-to-4 stages.
module onehot_dec #(
   parameter int N = 3
) (
   input  logic [N-1:0]      sel,
   input  logic              en,
   output logic [2**N-1:0]   d
);

   generate
      if (N == 1) begin : g_leaf1
         assign d = {en & sel[0], en & ~sel[0]};
      end else if (N == 2) begin : g_leaf2
         assign d = {en &  sel[1] &  sel[0],
                     en &  sel[1] & ~sel[0],
                     en & ~sel[1] &  sel[0],
                     en & ~sel[1] & ~sel[0]};
      end else begin : g_tree
         logic [3:0]            lo_s;
         logic [2**(N-2)-1:0]   hi_s;

         // Low pair is always decoded; the enable gates only the upper tree.
         onehot_dec #(.N(2)) u_lo (
            .sel (sel[1:0]),
            .en  (1'b1),
            .d   (lo_s)
         );

         onehot_dec #(.N(N-2)) u_hi (
            .sel (sel[N-1:2]),
            .en  (en),
            .d   (hi_s)
         );

         for (genvar i = 0; i < 2**(N-2); i++) begin : g_cross
            assign d[i*4 +: 4] = lo_s & {4{hi_s[i]}};
         end
      end
   endgenerate

endmodule : onehot_dec

// File: rtl/decoder_scan.sv
// Registered N-to-2^N decoder with valid/ready on both sides.
// Define DECODER_SCAN_EN to compile in the auto-scan mode (SCAN state, counters, live busy).
module decoder_scan #(
   parameter int N          = 3,
   parameter int ACTIVE_LOW = 0,
   parameter int SCAN_DWELL = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N-1:0]      sel,
   input  logic              en,
   input  logic              mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2**N-1:0]   d,
   output logic              busy
);
   import decoder_pkg::*;

   localparam int              W      = 2**N;
   localparam logic [W-1:0]    D_IDLE = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

   state_e          state_r, state_nxt_s;
   logic [W-1:0]    d_r;
   logic [W-1:0]    dec_d_s;
   logic [N-1:0]    dec_sel_s;
   logic            dec_en_s;
   logic            load_d_s;
   logic            out_valid_r;
   logic            busy_r;
   logic            in_ready_s;
   logic            accept_s;
   logic            mode_eff_s;
   logic            scan_req_s;

`ifdef DECODER_SCAN_EN
   localparam int DW = $clog2(SCAN_DWELL + 1);

   logic [N-1:0]    pos_r, pos_nxt_s;
   logic [N-1:0]    beat_r, beat_nxt_s;
   logic [DW-1:0]   dwell_r, dwell_nxt_s;

   assign mode_eff_s = mode;
`else
   // Without the scan feature every request is forced to direct mode.
   assign mode_eff_s = mode & MODE_DIRECT;
`endif

   assign accept_s   = in_valid & in_ready_s;
   assign scan_req_s = en & (mode_eff_s == MODE_SCAN);

   // Upstream ready: combinational from state and out_ready, held low during reset.
   always_comb begin
      in_ready_s = 1'b0;
      case (state_r)
         ST_IDLE: in_ready_s = 1'b1;
         ST_HOLD: in_ready_s = out_ready;
         default: in_ready_s = 1'b0;
      endcase
      if (rst) begin
         in_ready_s = 1'b0;
      end else begin
         in_ready_s = in_ready_s;
      end
   end

   // Next-state, decoder input selection and counter updates.
   always_comb begin
      state_nxt_s = state_r;
      load_d_s    = 1'b0;
      dec_sel_s   = sel;
      dec_en_s    = en;
`ifdef DECODER_SCAN_EN
      pos_nxt_s   = pos_r;
      beat_nxt_s  = beat_r;
      dwell_nxt_s = dwell_r;
`endif
      case (state_r)
         ST_IDLE, ST_HOLD: begin
            if (accept_s) begin
               load_d_s    = 1'b1;
               state_nxt_s = scan_req_s ? ST_SCAN : ST_HOLD;
`ifdef DECODER_SCAN_EN
               if (scan_req_s) begin
                  pos_nxt_s   = sel;
                  beat_nxt_s  = {N{1'b1}};
                  dwell_nxt_s = DW'(SCAN_DWELL - 1);
               end else begin
                  pos_nxt_s   = pos_r;
               end
`endif
            end else if ((state_r == ST_HOLD) && out_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = state_r;
            end
         end
`ifdef DECODER_SCAN_EN
         ST_SCAN: begin
            dec_sel_s = pos_r + N'(1);
            dec_en_s  = 1'b1;
            if (dwell_r != {DW{1'b0}}) begin
               dwell_nxt_s = dwell_r - DW'(1);
            end else if (!out_ready) begin
               dwell_nxt_s = dwell_r;
            end else if (beat_r != {N{1'b0}}) begin
               load_d_s    = 1'b1;
               pos_nxt_s   = pos_r + N'(1);
               beat_nxt_s  = beat_r - N'(1);
               dwell_nxt_s = DW'(SCAN_DWELL - 1);
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
`endif
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   onehot_dec #(.N(N)) u_dec (
      .sel (dec_sel_s),
      .en  (dec_en_s),
      .d   (dec_d_s)
   );

   // State, output register and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         d_r         <= D_IDLE;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         if (load_d_s) begin
            d_r <= dec_d_s ^ D_IDLE;
         end else begin
            d_r <= d_r;
         end
         out_valid_r <= (state_nxt_s != ST_IDLE);
         busy_r      <= (state_nxt_s == ST_SCAN);
      end
   end

`ifdef DECODER_SCAN_EN
   // Scan position, remaining-beat and dwell counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         pos_r   <= {N{1'b0}};
         beat_r  <= {N{1'b0}};
         dwell_r <= {DW{1'b0}};
      end else begin
         pos_r   <= pos_nxt_s;
         beat_r  <= beat_nxt_s;
         dwell_r <= dwell_nxt_s;
      end
   end
`endif

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign d         = d_r;
   assign busy      = busy_r;

endmodule : decoder_scan

// File: tb/tb_decoder_scan.sv
// Directed self-checking bench for decoder_scan (N=3, SCAN_DWELL=2), with an ACTIVE_LOW twin instance.
module tb_decoder_scan;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [2:0] sel;
   logic       en;
   logic       mode;
   logic       out_ready;
   logic       in_ready, in_ready_al;
   logic       out_valid, out_valid_al;
   logic [7:0] d, d_al;
   logic       busy, busy_al;

   int errors;
   int checks;

   decoder_scan #(.N(3), .ACTIVE_LOW(0), .SCAN_DWELL(2)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .en(en), .mode(mode), .out_valid(out_valid),
      .out_ready(out_ready), .d(d), .busy(busy)
   );

   decoder_scan #(.N(3), .ACTIVE_LOW(1), .SCAN_DWELL(2)) u_dut_al (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_al),
      .sel(sel), .en(en), .mode(mode), .out_valid(out_valid_al),
      .out_ready(out_ready), .d(d_al), .busy(busy_al)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; sel = 3'd0; en = 1'b0; mode = 1'b0; out_ready = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
      tick();
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL rst_d: got %h expected 00", d); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
      checks++;
      if (d_al !== 8'hFF) begin errors++; $display("FAIL rst_d_al: got %h expected ff", d_al); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready2: got %b expected 0", in_ready); end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_direct();
      out_ready = 1'b1; mode = 1'b0;
      in_valid = 1'b1; sel = 3'd5; en = 1'b1;
      tick();
      checks++;
      if (d !== 8'h20) begin errors++; $display("FAIL dir_sel5: got %h expected 20", d); end
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL dir_valid: got %b expected 1", out_valid); end
      checks++;
      if (d_al !== 8'hDF) begin errors++; $display("FAIL dir_sel5_al: got %h expected df", d_al); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL dir_hold_ready: got %b expected 1", in_ready); end
      sel = 3'd3; en = 1'b0;
      tick();
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL dir_en0: got %h expected 00", d); end
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL dir_en0_valid: got %b expected 1", out_valid); end
      checks++;
      if (d_al !== 8'hFF) begin errors++; $display("FAIL dir_en0_al: got %h expected ff", d_al); end
      sel = 3'd0; en = 1'b1;
      tick();
      checks++;
      if (d !== 8'h01) begin errors++; $display("FAIL dir_sel0: got %h expected 01", d); end
      checks++;
      if (d_al !== 8'hFE) begin errors++; $display("FAIL dir_sel0_al: got %h expected fe", d_al); end
      in_valid = 1'b0; sel = 3'd6;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL dir_idle_valid: got %b expected 0", out_valid); end
      checks++;
      if (d !== 8'h01) begin errors++; $display("FAIL dir_idle_keep: got %h expected 01", d); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0; mode = 1'b0;
      in_valid = 1'b1; sel = 3'd1; en = 1'b1;
      tick();
      checks++;
      if (d !== 8'h02) begin errors++; $display("FAIL bp_load: got %h expected 02", d); end
      sel = 3'd7;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b expected 0", in_ready); end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (d !== 8'h02 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_freeze: got d=%h v=%b expected d=02 v=1", d, out_valid);
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
      tick();
      checks++;
      if (d !== 8'h80) begin errors++; $display("FAIL bp_release_d: got %h expected 80", d); end
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0 || d !== 8'h80) begin
         errors++; $display("FAIL bp_drain: got d=%h v=%b expected d=80 v=0", d, out_valid);
      end
   endtask

`ifdef DECODER_SCAN_EN
   task automatic test_scan_wrap();
      logic [7:0] exp_d;
      out_ready = 1'b1; in_valid = 1'b1; mode = 1'b1; sel = 3'd6; en = 1'b1;
      tick();
      in_valid = 1'b0; mode = 1'b0;
      for (int k = 0; k < 16; k++) begin
         exp_d = 8'h01 << ((6 + k / 2) % 8);
         checks++;
         if (d !== exp_d || busy !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL scan_k%0d: got d=%h busy=%b v=%b rdy=%b expected d=%h busy=1 v=1 rdy=0",
                     k, d, busy, out_valid, in_ready, exp_d);
         end
         tick();
      end
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL scan_end: got busy=%b v=%b expected 0 0", busy, out_valid);
      end
   endtask

   task automatic test_stall_reset();
      logic [7:0] exp_d;
      out_ready = 1'b1; in_valid = 1'b1; mode = 1'b1; sel = 3'd6; en = 1'b1;
      tick();
      in_valid = 1'b0; mode = 1'b0;
      for (int k = 0; k <= 13; k++) begin
         if (k < 2)       exp_d = 8'h40;
         else if (k < 4)  exp_d = 8'h80;
         else if (k < 11) exp_d = 8'h01;
         else if (k < 13) exp_d = 8'h02;
         else             exp_d = 8'h04;
         checks++;
         if (d !== exp_d) begin errors++; $display("FAIL stall_k%0d: got %h expected %h", k, d, exp_d); end
         out_ready = (k >= 5 && k <= 9) ? 1'b0 : 1'b1;
         if (k == 13) rst = 1'b1;
         tick();
      end
      checks++;
      if (d !== 8'h00 || busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL stall_rst: got d=%h busy=%b v=%b rdy=%b expected 00 0 0 0", d, busy, out_valid, in_ready);
      end
      rst = 1'b0; out_ready = 1'b1;
      tick();
   endtask
`else
   task automatic test_mode_ignored();
      out_ready = 1'b1; in_valid = 1'b1; mode = 1'b1; sel = 3'd2; en = 1'b1;
      tick();
      in_valid = 1'b0; mode = 1'b0;
      checks++;
      if (d !== 8'h04 || out_valid !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL mode_ign: got d=%h v=%b busy=%b expected 04 1 0", d, out_valid, busy);
      end
      tick();
      checks++;
      if (d !== 8'h04 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL mode_ign_end: got d=%h v=%b busy=%b expected 04 0 0", d, out_valid, busy);
      end
   endtask
`endif

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_direct();
      test_backpressure();
`ifdef DECODER_SCAN_EN
      test_scan_wrap();
      test_stall_reset();
`else
      test_mode_ignored();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_decoder_scan

// File: doc/decoder_scan.md
# decoder_scan

Parametrised, registered binary-to-one-hot decoder with enable, a valid/ready handshake on both sides, and an optional auto-scan mode that sweeps every output in turn. It generalises the combinational 3-to-8 decoder to N-to-2^N and adds output registering, backpressure and sequencing. It sits between control logic that issues select codes and one-hot consumers such as row/digit drivers and bank selects.

## Interface
- `N`, default 3: select width; output width is 2^N.
- `ACTIVE_LOW`, default 0: when 1, `d` is inverted (one-cold), including its reset and idle value.
- `SCAN_DWELL`, default 4: minimum cycles each position is presented in scan mode; must be ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: request accepted when `in_valid && in_ready`.
- `sel` in N: binary select; in scan mode, the start index.
- `en` in 1: decoder enable, sampled with the request; 0 gives an all-inactive output.
- `mode` in 1: 0 direct, 1 scan. Ignored, and treated as 0, without `DECODER_SCAN_EN`.
- `out_valid` out 1: `d` holds a beat.
- `out_ready` in 1: consumer accepts the beat.
- `d` out 2^N: registered one-hot (or one-cold) output.
- `busy` out 1: high in SCAN state.

## Operation
- States:
  - IDLE: `out_valid`=0, `in_ready`=1.
  - HOLD: `out_valid`=1, `in_ready`=`out_ready`.
  - SCAN: `out_valid`=1, `in_ready`=0.
- Direct accept, from IDLE or HOLD:
  - `d` ← `en` ? (1 << `sel`) : 0.
  - Next state is HOLD.
- HOLD with `out_ready`=1 and no new accept: go to IDLE. `d` keeps its last value; it is not cleared.
- HOLD with `out_ready`=0: `d`, `out_valid` and state are frozen.
- Scan accept with `en`=1:
  - `d` ← 1 << `sel`; the position counter is loaded with `sel`; the dwell counter is loaded with `SCAN_DWELL`-1; the beat counter is loaded with 2^N-1; go to SCAN.
- Scan accept with `en`=0: behaves as a direct accept with a zero output.
- In SCAN, the dwell counter decrements each cycle, saturating at 0.
- Advance in SCAN happens when dwell=0 and `out_ready`=1:
  - If beats remain: position ← position+1, wrapping modulo 2^N (index 2^N-1 → 0); `d` updates; dwell reloads; beat counter decrements.
  - On the last beat: go to IDLE.
- A scan always presents exactly 2^N beats, starting at `sel`.
- Counter widths: position N bits; beat counter N bits; dwell counter $clog2(`SCAN_DWELL`+1) bits.
- `ACTIVE_LOW` applies only at the output register input; internal state is always active-high.

## Timing
- Reset values:
  - `d` = 0, or all ones if `ACTIVE_LOW`.
  - `out_valid`=0, `busy`=0, state IDLE, all counters 0.
  - `in_ready`=0 while `rst` is high.
- Latency: one cycle from the accept edge to the new `d` and `out_valid`=1.
- Throughput in direct mode: one request per cycle when `out_ready` is held at 1. `in_ready` is combinational from `out_ready`.
- In scan mode, each position is visible for at least `SCAN_DWELL` cycles; it stretches further while `out_ready`=0.
- `rst` asserted mid-scan: the reset values appear in the next cycle; the scan is abandoned.
- An accept and the HOLD→IDLE transition in the same cycle: the accept wins and the state stays HOLD.
- `sel`, `en` and `mode` are sampled only on an accept edge.

## Configuration
- `DECODER_SCAN_EN` defined: SCAN state, the three counters, `mode` handling and a live `busy` output are compiled in.
- `DECODER_SCAN_EN` undefined:
  - Only IDLE and HOLD exist; `mode` is ignored.
  - `busy` is tied to 0.
  - `SCAN_DWELL` is unused.
  - Direct-mode behaviour and timing are identical to the scan-enabled build.

## Structure
- Shared package `decoder_pkg`: state encoding constants (`ST_IDLE`, `ST_HOLD`, `ST_SCAN`) and the mode constants (`MODE_DIRECT`=0, `MODE_SCAN`=1).
- Sub-module `onehot_dec`: a purely combinational N-to-2^N decoder with enable, built recursively from 2-to-4 stages. It is instantiated once, feeding the output register.
- The FSM, counters and handshake logic live in `decoder_scan`.

## Test plan
All scenarios use N=3 and `SCAN_DWELL`=2 unless noted.
- Reset: hold `rst` for 2 cycles → `d`=8'h00, `out_valid`=0, `in_ready`=0 during reset and 1 after.
- Direct, with `out_ready`=1: `sel`=5, `en`=1 → next cycle `d`=8'h20, `out_valid`=1. Then `sel`=3, `en`=0 → `d`=8'h00, `out_valid`=1.
- Backpressure: with `out_ready`=0 in HOLD and `d`=8'h02, `in_valid` with `sel`=7 → `in_ready`=0 and `d` stays 8'h02. Raise `out_ready` → the next cycle gives `d`=8'h80.
- Scan wrap, with `out_ready`=1: `mode`=1, `sel`=6 → `d` runs 8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, two cycles each, with `busy`=1 throughout (16 cycles). Then IDLE, `busy`=0.
- Mid-scan reset and stall: stall `out_ready`=0 on the third beat for 5 cycles → `d`=8'h01 held for 7 cycles. Assert `rst` on the fifth beat → next cycle `d`=8'h00, IDLE.
- Build variants: with `ACTIVE_LOW`=1, `sel`=0 → `d`=8'hFE. Without `DECODER_SCAN_EN`, `mode`=1 with `sel`=2 → a single beat of `d`=8'h04.
